// File: rtl/irq_ctrl.sv
// Programmable interrupt controller: sync, edge/level latch, mask, priority encode, vector ack.
// Optional NMI routing (NMISEL register, nmirq, NMI vector at register 6) with IRQC_NMI_EN.
module irq_ctrl #(
    parameter int NUM_SRC     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src_n,
    input  logic [2:0]         reg_addr,
    input  logic [7:0]         reg_wdata,
    input  logic               reg_wr,
    input  logic               reg_rd,
    output logic [7:0]         reg_rdata,
    output logic               irq,
    output logic               nmirq,
    output logic [NUM_SRC-1:0] active_src
);

    typedef logic [NUM_SRC-1:0] src_t;

    localparam logic [2:0] A_STATUS = 3'd0;
    localparam logic [2:0] A_MASK   = 3'd1;
    localparam logic [2:0] A_MODE   = 3'd2;
    localparam logic [2:0] A_CLEAR  = 3'd3;
    localparam logic [2:0] A_VECTOR = 3'd4;
    localparam logic [2:0] A_NMISEL = 3'd5;
    localparam logic [2:0] A_NMIVEC = 3'd6;

    logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_q;
    src_t s, prev_q, fall, mask_q, mode_q, edge_q, edge_d, clr, pending, nmisel_q, wdata_src;
    logic [3:0] irq_pri, nmi_pri;

    // {found, index}; lowest index wins
    function automatic logic [3:0] prio(input src_t v);
        prio = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--)
            if (v[i]) prio = {1'b1, 3'(i)};
    endfunction

    assign s         = sync_q[SYNC_STAGES-1];
    assign fall      = prev_q & ~s;
    assign wdata_src = reg_wdata[NUM_SRC-1:0];

    // An edge arriving this clock is already visible, keeping edge and level latency equal
    assign pending = (mode_q & (edge_q | fall)) | (~mode_q & ~s);
    assign irq_pri = prio(pending & mask_q & ~nmisel_q);

    always_comb begin
        clr = '0;
        if (reg_wr && reg_addr == A_CLEAR)
            clr = clr | wdata_src;
        if (reg_wr && reg_addr == A_MODE)
            clr = clr | (mode_q & ~wdata_src);
        if (reg_rd && reg_addr == A_VECTOR && irq_pri[3])
            clr = clr | (src_t'(1) << irq_pri[2:0]);
        if (reg_rd && reg_addr == A_NMIVEC && nmi_pri[3])
            clr = clr | (src_t'(1) << nmi_pri[2:0]);
        edge_d = (edge_q & ~clr) | (fall & mode_q);
    end

    always_comb begin
        reg_rdata = 8'h00;
        case (reg_addr)
            A_STATUS: reg_rdata = 8'(pending);
            A_MASK:   reg_rdata = 8'(mask_q);
            A_MODE:   reg_rdata = 8'(mode_q);
            A_VECTOR: reg_rdata = {irq_pri[3], 4'b0000, irq_pri[2:0]};
            A_NMISEL: reg_rdata = 8'(nmisel_q);
            A_NMIVEC: reg_rdata = {nmi_pri[3], 4'b0000, nmi_pri[2:0]};
            default:  reg_rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q     <= '1;
            prev_q     <= '1;
            mask_q     <= '0;
            mode_q     <= '0;
            edge_q     <= '0;
            irq        <= 1'b1;
            active_src <= '0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], irq_src_n};
            prev_q     <= s;
            edge_q     <= edge_d;
            irq        <= ~|(pending & mask_q & ~nmisel_q);
            active_src <= pending & mask_q;
            if (reg_wr && reg_addr == A_MASK) mask_q <= wdata_src;
            if (reg_wr && reg_addr == A_MODE) mode_q <= wdata_src;
        end
    end

`ifdef IRQC_NMI_EN
    assign nmi_pri = prio(pending & mask_q & nmisel_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            nmisel_q <= '0;
            nmirq    <= 1'b1;
        end else begin
            nmirq <= ~|(pending & mask_q & nmisel_q);
            if (reg_wr && reg_addr == A_NMISEL) nmisel_q <= wdata_src;
        end
    end
`else
    // No NMI routing: all enabled sources go to irq, NMI vector never reports
    assign nmisel_q = '0;
    assign nmi_pri  = '0;
    assign nmirq    = 1'b1;
`endif

endmodule
